// File: rtl/noc_link_rx.sv
// noc_link_rx: credit-based receiving endpoint of a router-to-router link.
// Buffers incoming flits in a first-word-fall-through FIFO sized to the
// upstream credit count, returns one credit per dequeued flit and flags
// overflow and in-packet destination changes with sticky error bits.
//
// Output handshake: a flit is transferred on every rising clk_noc edge where
// out_valid && out_ready are both 1. out_valid depends only on registered
// state, and out_data/out_dest/out_last hold steady while out_valid=1 and
// out_ready=0. out_ready is ignored while out_valid=0.
module noc_link_rx #(
    parameter int FLIT_WIDTH        = 32,
    parameter int DEST_WIDTH        = 6,
    parameter int FLIT_BUFFER_DEPTH = 4,
    parameter int OCC_WIDTH         = $clog2(FLIT_BUFFER_DEPTH + 1)
) (
    input  logic                  clk_noc,
    input  logic                  rst_noc_sync,
    input  logic [FLIT_WIDTH-1:0] data_in,
    input  logic [DEST_WIDTH-1:0] dest_in,
    input  logic                  is_tail_in,
    input  logic                  send_in,
    output logic                  credit_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [FLIT_WIDTH-1:0] out_data,
    output logic [DEST_WIDTH-1:0] out_dest,
    output logic                  out_last,
    output logic [OCC_WIDTH-1:0]  occupancy,
    output logic                  overflow_err,
    output logic                  dest_err
);

    localparam int PTR_WIDTH = (FLIT_BUFFER_DEPTH > 1) ? $clog2(FLIT_BUFFER_DEPTH) : 1;
    localparam logic [PTR_WIDTH-1:0] PTR_LAST  = PTR_WIDTH'(FLIT_BUFFER_DEPTH - 1);
    localparam logic [OCC_WIDTH-1:0] OCC_FULL  = OCC_WIDTH'(FLIT_BUFFER_DEPTH);

    // Packet checker state; kept as a named signal so checkers can probe it.
    typedef enum logic {
        PKT_HEAD = 1'b0,
        PKT_BODY = 1'b1
    } pkt_state_t;

    logic [FLIT_WIDTH-1:0] data_mem [FLIT_BUFFER_DEPTH];
    logic [DEST_WIDTH-1:0] dest_mem [FLIT_BUFFER_DEPTH];
    logic                  tail_mem [FLIT_BUFFER_DEPTH];

    logic [PTR_WIDTH-1:0]  wr_ptr;
    logic [PTR_WIDTH-1:0]  rd_ptr;
    logic                  full;
    logic                  pop;
    logic                  push;
    logic                  overflow_set;

    pkt_state_t            pkt_state;
    pkt_state_t            pkt_state_next;
    logic [DEST_WIDTH-1:0] pkt_dest;
    logic [DEST_WIDTH-1:0] pkt_dest_next;
    logic                  dest_err_set;

    // A full FIFO still accepts a flit when the head leaves in the same cycle.
    assign full         = (occupancy == OCC_FULL);
    assign out_valid    = (occupancy != '0);
    assign pop          = out_valid && out_ready;
    assign push         = send_in && (!full || pop);
    assign overflow_set = send_in && full && !pop;

    assign out_data = data_mem[rd_ptr];
    assign out_dest = dest_mem[rd_ptr];
    assign out_last = tail_mem[rd_ptr];

    // Flit storage: written on accepted pushes only, contents need no reset.
    always_ff @(posedge clk_noc) begin
        if (push) begin
            data_mem[wr_ptr] <= data_in;
            dest_mem[wr_ptr] <= dest_in;
            tail_mem[wr_ptr] <= is_tail_in;
        end
    end

    // Pointers, occupancy, credit pulse and sticky overflow flag.
    always_ff @(posedge clk_noc) begin
        if (rst_noc_sync) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            occupancy    <= '0;
            credit_out   <= 1'b0;
            overflow_err <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   occupancy <= occupancy + 1'b1;
                2'b01:   occupancy <= occupancy - 1'b1;
                default: occupancy <= occupancy;
            endcase
            credit_out <= pop;
            if (overflow_set) begin
                overflow_err <= 1'b1;
            end
        end
    end

    // Packet checker registers and sticky destination error.
    always_ff @(posedge clk_noc) begin
        if (rst_noc_sync) begin
            pkt_state <= PKT_HEAD;
            pkt_dest  <= '0;
            dest_err  <= 1'b0;
        end else begin
            pkt_state <= pkt_state_next;
            pkt_dest  <= pkt_dest_next;
            if (dest_err_set) begin
                dest_err <= 1'b1;
            end
        end
    end

    // Packet checker next state: only accepted flits advance it.
    always_comb begin
        pkt_state_next = pkt_state;
        pkt_dest_next  = pkt_dest;
        dest_err_set   = 1'b0;
        case (pkt_state)
            PKT_HEAD: begin
                if (push && !is_tail_in) begin
                    pkt_dest_next  = dest_in;
                    pkt_state_next = PKT_BODY;
                end
            end
            PKT_BODY: begin
                if (push) begin
                    if (dest_in != pkt_dest) begin
                        dest_err_set = 1'b1;
                    end
                    if (is_tail_in) begin
                        pkt_state_next = PKT_HEAD;
                    end
                end
            end
            default: pkt_state_next = PKT_HEAD;
        endcase
    end

endmodule

// File: doc/noc_link_rx.md
# noc_link_rx

Credit-based receiving endpoint for one router-to-router link. It accepts flits driven by an upstream router output port (`data`/`dest`/`is_tail`/`send`) into a FIFO sized to the upstream credit count. It returns one credit per dequeued flit and presents the buffered flits as a valid/ready stream. It is the far end of a router output port, used where a link terminates in non-router logic such as a monitor, bridge or test sink.

## Interface

Parameters:
- `FLIT_WIDTH`, 32: flit payload width.
- `DEST_WIDTH`, 6: destination field width (TDEST_WIDTH + TID_WIDTH).
- `FLIT_BUFFER_DEPTH`, 4: FIFO depth. Must equal the upstream initial credit count; ≥2.
- `OCC_WIDTH`, $clog2(FLIT_BUFFER_DEPTH+1): occupancy counter width.

Ports:
- `clk_noc` in 1: sole clock.
- `rst_noc_sync` in 1: synchronous, active-high reset.
- `data_in` in FLIT_WIDTH: flit payload.
- `dest_in` in DEST_WIDTH: flit destination.
- `is_tail_in` in 1: last flit of packet.
- `send_in` in 1: flit valid. Single-cycle qualifier, with no backpressure.
- `credit_out` in the out direction, 1: one-cycle pulse returning one buffer slot upstream.
- `out_valid` out 1: head flit available.
- `out_ready` in 1: consumer accepts head flit.
- `out_data` out FLIT_WIDTH, `out_dest` out DEST_WIDTH, `out_last` out 1: head flit fields.
- `occupancy` out OCC_WIDTH: flits currently stored.
- `overflow_err` out 1: sticky; a flit arrived while full with no simultaneous pop.
- `dest_err` out 1: sticky; dest changed inside a packet.

## Operation

- Storage: circular FIFO, FLIT_BUFFER_DEPTH entries, each {data, dest, is_tail}.
  - Read/write pointers wrap modulo depth.
  - Separate occupancy counter; no pointer-MSB trick needed.
- Push: every cycle with `send_in`=1.
  - Accepted if not full, or if full with a pop in the same cycle.
  - Otherwise the flit is dropped, `overflow_err` is set, and occupancy is unchanged.
- Pop: `out_valid && out_ready`.
- Occupancy update: +1 on push only, −1 on pop only, unchanged on both.
- Head presentation: first-word-fall-through. `out_valid` = occupancy≠0, and `out_data`/`out_dest`/`out_last` are the entry at the read pointer. Fields are don't-care when `out_valid`=0.
- Credit return: `credit_out` is a register set to 1 in the cycle after each pop. Exactly one pulse per popped flit; never pulsed for dropped flits.
- Packet checker, input side, states HEAD and BODY:
  - HEAD, accepted push with `is_tail_in`=0: latch `dest_in`, go to BODY.
  - HEAD, accepted push with `is_tail_in`=1: single-flit packet, stay in HEAD.
  - BODY, accepted push with `dest_in` ≠ latched dest: set `dest_err`. The flit is still stored.
  - BODY, accepted push with `is_tail_in`=1: go to HEAD.
  - Dropped flits do not advance the checker.
- Errors clear only on reset.
- `out_ready` while `out_valid`=0: ignored.

## Timing

- Reset (`rst_noc_sync`=1 at an edge):
  - Pointers, occupancy, `credit_out`, `overflow_err` and `dest_err` go to 0; checker goes to HEAD.
  - Therefore `out_valid`=0, `credit_out`=0, `occupancy`=0.
  - Stored flits are discarded with no credits returned; upstream resets from the same source.
  - A pop in the reset cycle produces no `credit_out`.
- Push latency: flit with `send_in` at edge t gives `out_valid`=1 and its fields on outputs after edge t (cycle t+1), if the FIFO was empty.
- Credit latency: pop at edge t gives `credit_out`=1 during cycle t+1 only. Back-to-back pops give back-to-back pulses.
- Full throughput: one push and one pop per cycle sustained at any occupancy, including the full-with-pop case.
- Empty with push and `out_ready`=1 in the same cycle: no pop; the flit is visible next cycle.
- No combinational path from `send_in`/`data_in` to any output. `out_ready` affects outputs only after the clock edge.

## Test plan

- Reset, then a 3-flit packet (dest=0x15, data 0xA0,0xA1,0xA2, tail on the last) with `out_ready`=1 → `out_valid` rises 1 cycle after the first send. Outputs are 0xA0..0xA2 with `out_last` on 0xA2. Three `credit_out` pulses, each 1 cycle after its pop. Errors stay 0.
- `out_ready`=0, send 4 flits (depth 4) → `occupancy`=4, no credits. A 5th send with `out_ready`=0 → `overflow_err`=1, occupancy stays 4. Then drain → 4 credits and the original 4 flits in order.
- Full FIFO, send and pop in the same cycle → occupancy stays 4, no error. The new flit emerges after the remaining 3.
- Packet dest=0x03 head, then body flit dest=0x04 → `dest_err`=1 and the flit is delivered. Following tail, then a single-flit packet dest=0x09 → no further error change.
- Continuous send+pop for 20 cycles with pointer wrap → data matches the sent sequence 0..19, 20 credit pulses, occupancy constant.
- Reset asserted with 3 flits stored and a pop pending → next cycle `out_valid`=0, `occupancy`=0, no `credit_out`, errors cleared.
